// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared state, opcode and control encodings
// Used by the multicycle RV32I control FSM.
package rv32i_ctrl_pkg;

  typedef enum logic [3:0] {
    BOOT,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_U,
    WB_ALU,
    ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JAL,
    JALR,
    TRAP
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_ECALL   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

endpackage

// File: rtl/rv32i_multicycle_ctrl_branch_cond.sv
// rtl/rv32i_multicycle_ctrl_branch_cond.sv - branch taken/illegal decode
// Interprets the ALU zero flag after the SUB/SLT/SLTU compare chosen by funct3.
module branch_cond (
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      // BEQ on SUB, BGE/BGEU when SLT/SLTU produced 0
      3'b000, 3'b101, 3'b111: taken_o = zero_i;
      3'b001, 3'b100, 3'b110: taken_o = !zero_i;
      default:                illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
// Moore-decoded strobes, with memory-handshake gating and a wait-cycle timeout trap.
module rv32i_multicycle_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] Alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  // Counter holds completed wait cycles; the limit cycle itself traps.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             mem_wait;
  logic             timeout_hit;
  logic             br_taken;
  logic             br_illegal;

  branch_cond u_branch_cond (
    .funct3_i  (funct3),
    .zero_i    (zero),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  assign mem_wait    = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR)) && !mem_ready;
  assign timeout_hit = mem_wait && (cnt_q == CNT_LIMIT);
  assign trap_cause  = cause_q;

  always_comb begin
    cnt_d = '0;
    if (mem_wait && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    Alu_op     = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    instr_done = 1'b0;
    trap       = 1'b0;

    case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      DECODE: begin
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OPC_OP:               state_d = EXEC_R;
          OPC_OP_IMM:           state_d = EXEC_I;
          OPC_LOAD, OPC_STORE:  state_d = ADDR;
          OPC_BRANCH:           state_d = BRANCH;
          OPC_JAL:              state_d = JAL;
          OPC_JALR:             state_d = JALR;
          OPC_LUI, OPC_AUIPC:   state_d = EXEC_U;
          OPC_FENCE: begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
          OPC_SYSTEM: begin
            state_d = TRAP;
            cause_d = CAUSE_ECALL;
          end
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        Alu_op    = ALU_RTYPE;
        state_d   = WB_ALU;
      end

      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        Alu_op    = ALU_ITYPE;
        state_d   = WB_ALU;
      end

      EXEC_U: begin
        alu_src_a = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
        alu_src_b = SRC_B_IMM;
        state_d   = WB_ALU;
      end

      WB_ALU: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
      end

      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = WB_MDR;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        Alu_op    = ALU_BRANCH;
        pc_src    = 1'b1;
        if (br_illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          pc_write   = br_taken;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end

      // Target was formed in DECODE and sits in ALUOut
      JAL: begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        reg_write  = 1'b1;
        wb_sel     = WB_PC;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        wb_sel     = WB_PC;
        instr_done = 1'b1;
        state_d    = FETCH;
      end

      TRAP: trap = 1'b1;

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - directed self-checking bench for the control FSM
// Observed outputs are packed into one vector and compared against hand-built expectations.
module tb_rv32i_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [1:0] Alu_op, alu_src_a, alu_src_b, wb_sel, trap_cause;
  logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, instr_done, trap;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [18:0] obs, e;

  assign obs = {Alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write, iord,
                mem_read, mem_write, reg_write, wb_sel, instr_done, trap, trap_cause};

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .Alu_op(Alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
    .pc_src(pc_src), .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
  );

  // Field order: alu, a, b, pcw, pcs, irw, iord, mr, mw, rw, wb, done, trap, cause
  function automatic logic [18:0] pk(input int alu, input int a, input int b, input int pcw,
                                     input int pcs, input int irw, input int io, input int mr,
                                     input int mw, input int rw, input int wb, input int dn,
                                     input int tr, input int ca);
    return {alu[1:0], a[1:0], b[1:0], pcw[0], pcs[0], irw[0], io[0], mr[0], mw[0], rw[0],
            wb[1:0], dn[0], tr[0], ca[1:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, e); end
    rst = 1'b0;
    #1;
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL boot: got %h expected %h", obs, e); end
    tick();
    mem_ready = 1'b0;
    #1;
    e = pk(0,0,1,0,0,0,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL fetch_wait: got %h expected %h", obs, e); end
    mem_ready = 1'b1;
    #1;
    e = pk(0,0,1,1,0,1,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL fetch_ready: got %h expected %h", obs, e); end
  endtask

  task automatic test_alu_types;
    logic [18:0] ex;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin opcode = 7'b0110011; ex = pk(2,1,0,0,0,0,0,0,0,0,0,0,0,0); end
        1:       begin opcode = 7'b0010011; ex = pk(3,1,2,0,0,0,0,0,0,0,0,0,0,0); end
        2:       begin opcode = 7'b0110111; ex = pk(0,2,2,0,0,0,0,0,0,0,0,0,0,0); end
        default: begin opcode = 7'b0010111; ex = pk(0,0,2,0,0,0,0,0,0,0,0,0,0,0); end
      endcase
      mem_ready = 1'b1;
      #1;
      e = pk(0,0,1,1,0,1,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL alu_fetch[%0d]: got %h expected %h", i, obs, e); end
      tick();
      e = pk(0,0,2,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL alu_decode[%0d]: got %h expected %h", i, obs, e); end
      tick();
      n_chk++; if (obs !== ex) begin n_fail++; $display("FAIL alu_exec[%0d]: got %h expected %h", i, obs, ex); end
      tick();
      e = pk(0,0,0,0,0,0,0,0,0,1,0,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL alu_wb[%0d]: got %h expected %h", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_load_wait;
    opcode = 7'b0000011;
    mem_ready = 1'b1;
    #1;
    tick();
    tick();
    e = pk(0,1,2,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ld_addr: got %h expected %h", obs, e); end
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      e = pk(0,0,0,0,0,0,1,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ld_wait[%0d]: got %h expected %h", i, obs, e); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    e = pk(0,0,0,0,0,0,1,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ld_ready: got %h expected %h", obs, e); end
    tick();
    e = pk(0,0,0,0,0,0,0,0,0,1,1,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ld_wb: got %h expected %h", obs, e); end
    tick();
  endtask

  task automatic test_store;
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    #1;
    tick();
    tick();
    tick();
    e = pk(0,0,0,0,0,0,1,0,1,0,0,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL st_mem: got %h expected %h", obs, e); end
    tick();
    e = pk(0,0,1,1,0,1,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL st_next_fetch: got %h expected %h", obs, e); end
  endtask

  task automatic test_branch;
    logic [2:0] f3;
    logic       z;
    int         pcw;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       begin f3 = 3'b001; z = 1'b1; pcw = 0; end
        1:       begin f3 = 3'b001; z = 1'b0; pcw = 1; end
        2:       begin f3 = 3'b101; z = 1'b1; pcw = 1; end
        3:       begin f3 = 3'b000; z = 1'b0; pcw = 0; end
        default: begin f3 = 3'b110; z = 1'b0; pcw = 1; end
      endcase
      opcode = 7'b1100011;
      funct3 = f3;
      zero = z;
      mem_ready = 1'b1;
      #1;
      tick();
      tick();
      e = pk(1,1,0,pcw,1,0,0,0,0,0,0,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL br[%0d] f3=%b z=%b: got %h expected %h", i, f3, z, obs, e); end
      tick();
    end
    funct3 = 3'b000;
    zero = 1'b0;
  endtask

  task automatic test_jumps;
    opcode = 7'b1101111;
    #1;
    tick();
    tick();
    e = pk(0,0,0,1,1,0,0,0,0,1,2,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL jal: got %h expected %h", obs, e); end
    tick();
    opcode = 7'b1100111;
    #1;
    tick();
    tick();
    e = pk(0,1,2,1,0,0,0,0,0,1,2,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL jalr: got %h expected %h", obs, e); end
    tick();
  endtask

  task automatic test_fence;
    opcode = 7'b0001111;
    #1;
    tick();
    e = pk(0,0,2,0,0,0,0,0,0,0,0,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL fence_decode: got %h expected %h", obs, e); end
    tick();
    e = pk(0,0,1,1,0,1,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL fence_next: got %h expected %h", obs, e); end
  endtask

  task automatic test_timeout_edge;
    opcode = 7'b0001111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      #1;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    e = pk(0,0,1,1,0,1,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL to_edge_fetch: got %h expected %h", obs, e); end
    tick();
    e = pk(0,0,2,0,0,0,0,0,0,0,0,1,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL to_edge_decode: got %h expected %h", obs, e); end
    tick();
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #1;
      e = pk(0,0,1,0,0,0,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL to_wait[%0d]: got %h expected %h", i, obs, e); end
      tick();
    end
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,3); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL to_trap: got %h expected %h", obs, e); end
    mem_ready = 1'b1;
    tick();
    tick();
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,3); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL to_hold: got %h expected %h", obs, e); end
    do_reset();
  endtask

  task automatic test_traps;
    logic [18:0] ex;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin opcode = 7'b1111111; funct3 = 3'b000; ex = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,1); end
        1:       begin opcode = 7'b1110011; funct3 = 3'b000; ex = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,2); end
        default: begin opcode = 7'b1100011; funct3 = 3'b010; ex = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,1); end
      endcase
      mem_ready = 1'b1;
      #1;
      tick();
      tick();
      if (i == 2) begin
        e = pk(1,1,0,0,1,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL br_illegal_state: got %h expected %h", obs, e); end
        tick();
      end
      n_chk++; if (obs !== ex) begin n_fail++; $display("FAIL trap[%0d]: got %h expected %h", i, obs, ex); end
      do_reset();
    end
    funct3 = 3'b000;
  endtask

  task automatic test_rst_mid_store;
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    #1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    e = pk(0,0,0,0,0,0,1,0,1,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rs_memwr: got %h expected %h", obs, e); end
    rst = 1'b1;
    #1;
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rs_drop: got %h expected %h", obs, e); end
    tick();
    rst = 1'b0;
    #1;
    e = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rs_boot: got %h expected %h", obs, e); end
    tick();
    e = pk(0,0,1,0,0,0,0,1,0,0,0,0,0,0); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL rs_fetch: got %h expected %h", obs, e); end
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_types();
    test_load_wait();
    test_store();
    test_branch();
    test_jumps();
    test_fence();
    test_timeout_edge();
    test_timeout();
    test_traps();
    test_rst_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences one shared ALU datapath (ALU plus ALU-control decoder) through fetch, decode, execute, memory and write-back.
- Drives Alu_op, operand-mux selects, register/PC/IR write enables and memory strobes.
- Consumes the opcode, funct3, the ALU zero flag and a memory ready handshake.

Parameters:
- TIMEOUT_CYCLES, 255, consecutive cycles a memory request may wait for mem_ready before a timeout trap is taken.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- Alu_op  out  2  00 add, 01 branch compare, 10 R-type (funct-decoded), 11 I-type (funct-decoded)
- alu_src_a  out  2  00 old PC, 01 rs1, 10 constant 0
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = ALU result this cycle, 1 = ALUOut register
- ir_write  out  1  latch IR and old PC
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  read request, held until mem_ready
- mem_write  out  1  write request, held until mem_ready
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALUOut, 01 memory data register, 10 PC (already +4)
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction
- trap  out  1  sticky; core halted
- trap_cause  out  2  00 none, 01 illegal, 10 ecall/ebreak, 11 memory timeout

Behaviour:
- Reset: rst=1 asynchronously forces state BOOT, clears timeout counter, trap=0, trap_cause=00. Applies mid-operation: all strobes drop immediately.
- BOOT: all outputs 0; next state FETCH.
- Outputs are Moore-decoded from state, except: pc_write in BRANCH; instr_done; strobes gated by mem_ready. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, src_a=PC, src_b=4, Alu_op=00.
  - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then DECODE.
  - mem_ready=0: stay.
- DECODE: src_a=old PC, src_b=imm, Alu_op=00 (branch/JAL target into ALUOut). Dispatch on opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 / 0010111 -> EXEC_U
  - 0001111 (FENCE) -> FETCH with instr_done=1
  - 1110011 -> TRAP, cause 10
  - other -> TRAP, cause 01
- EXEC_R: src_a=rs1, src_b=rs2, Alu_op=10; next WB_ALU.
- EXEC_I: src_a=rs1, src_b=imm, Alu_op=11; next WB_ALU.
- EXEC_U: src_b=imm, Alu_op=00; src_a=const 0 for LUI, old PC for AUIPC; next WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00, instr_done=1; next FETCH.
- ADDR: src_a=rs1, src_b=imm, Alu_op=00; load -> MEM_RD, store -> MEM_WR.
- MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, wb_sel=01, instr_done=1; next FETCH.
- MEM_WR: mem_write=1, iord=1; on mem_ready: instr_done=1, next FETCH.
- BRANCH: src_a=rs1, src_b=rs2, Alu_op=01; pc_src=1; pc_write=taken; instr_done=1; next FETCH.
  - ALU control maps funct3 000/001 -> SUB, 100/101 -> SLT, 110/111 -> SLTU.
  - taken = zero for 000/101/111; taken = !zero for 001/100/110.
  - funct3 010/011 -> TRAP, cause 01, no pc_write.
- JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=10, instr_done=1; next FETCH.
- JALR: src_a=rs1, src_b=imm, Alu_op=00, pc_write=1, pc_src=0, reg_write=1, wb_sel=10, instr_done=1; next FETCH. The datapath clears bit 0. The register file captures the pre-update PC (old PC+4).
- Timeout:
  - Counter increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Cleared on mem_ready or on leaving those states.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is TRAP, cause 11, and strobes drop.
  - mem_ready in the same cycle as the limit wins: no trap.
- TRAP: trap=1, all strobes 0; held until rst.
- Zero-wait latencies (cycles):
  - R/I/U: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL/JALR: 3
  - FENCE: 2

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - state_t enum: BOOT, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_U, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR, TRAP.
  - Opcode constants.
  - Alu_op, src_a/src_b and wb_sel encodings.
  - trap_cause encodings.
- One sub-module: branch_cond (funct3, zero -> taken, illegal).

Test Plan:
- rst held, mem_ready=1 -> all outputs 0. After release: BOOT, then FETCH with mem_read=1, iord=0, Alu_op=00, src_b=01.
- R-type (0110011), mem_ready always 1 -> states FETCH, DECODE, EXEC_R (Alu_op=10), WB_ALU (reg_write=1); instr_done on cycle 4.
- Load with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord=1 held 4 cycles; WB_MEM wb_sel=01; no trap.
- BNE (funct3 001), zero=1 -> pc_write=0. Repeat with zero=0 -> pc_write=1, pc_src=1. BGE (101), zero=1 -> pc_write=1.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> trap=1, trap_cause=11 after 4 wait cycles; mem_read=0 thereafter.
- Opcode 1111111 -> TRAP, cause 01. rst pulse mid MEM_WR -> mem_write drops same cycle, restart from BOOT.
